// File: rtl/aes_encipher_iter_if.sv
// rtl/aes_encipher_iter_if.sv - start/result, key memory and shared S-box port bundle
interface aes_encipher_iter_if;
   logic         next;
   logic         keylen;
   logic [127:0] block;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] new_block;
   logic         ready;

   modport master (
      output next, keylen, block, round_key, new_sboxw,
      input  round, sboxw, new_block, ready
   );

   modport slave (
      input  next, keylen, block, round_key, new_sboxw,
      output round, sboxw, new_block, ready
   );
endinterface

// File: rtl/aes_encipher_iter.sv
// rtl/aes_encipher_iter.sv - iterative AES-128/256 encipher, one S-box column per cycle
module aes_encipher_iter (
   input  logic                    clk,
   input  logic                    reset_n,
   aes_encipher_iter_if.slave      bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SBOX = 2'd1;
   localparam logic [1:0] MAIN = 2'd2;

   logic [127:0] block_reg;
   logic [3:0]   round_ctr_reg;
   logic [1:0]   word_ctr_reg;
   logic         keylen_reg;
   logic         ready_reg;
   logic [1:0]   state_reg;

   logic [3:0]   num_rounds;
   logic [127:0] sbox_block;
   logic [127:0] shifted;
   logic [127:0] mixed;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   // Byte 4c+r of the result comes from column (c+r) mod 4 of the same row.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32 * c -: 8];
         a1 = s[119 - 32 * c -: 8];
         a2 = s[111 - 32 * c -: 8];
         a3 = s[103 - 32 * c -: 8];
         o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   assign num_rounds = keylen_reg ? 4'd14 : 4'd10;
   assign shifted    = shift_rows(block_reg);
   assign mixed      = mix_columns(shifted);

   always_comb begin
      sbox_block = block_reg;
      bus.sboxw  = block_reg[127:96];
      case (word_ctr_reg)
         2'd0: begin
            bus.sboxw          = block_reg[127:96];
            sbox_block[127:96] = bus.new_sboxw;
         end
         2'd1: begin
            bus.sboxw          = block_reg[95:64];
            sbox_block[95:64]  = bus.new_sboxw;
         end
         2'd2: begin
            bus.sboxw          = block_reg[63:32];
            sbox_block[63:32]  = bus.new_sboxw;
         end
         default: begin
            bus.sboxw          = block_reg[31:0];
            sbox_block[31:0]   = bus.new_sboxw;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         block_reg     <= '0;
         round_ctr_reg <= 4'd0;
         word_ctr_reg  <= 2'd0;
         keylen_reg    <= 1'b0;
         ready_reg     <= 1'b1;
         state_reg     <= IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.next) begin
                  block_reg     <= bus.block ^ bus.round_key;
                  keylen_reg    <= bus.keylen;
                  round_ctr_reg <= 4'd1;
                  word_ctr_reg  <= 2'd0;
                  ready_reg     <= 1'b0;
                  state_reg     <= SBOX;
               end
            end
            SBOX: begin
               block_reg    <= sbox_block;
               word_ctr_reg <= word_ctr_reg + 2'd1;
               if (word_ctr_reg == 2'd3) begin
                  state_reg <= MAIN;
               end
            end
            MAIN: begin
               if (round_ctr_reg < num_rounds) begin
                  block_reg     <= mixed ^ bus.round_key;
                  round_ctr_reg <= round_ctr_reg + 4'd1;
                  state_reg     <= SBOX;
               end else begin
                  block_reg     <= shifted ^ bus.round_key;
                  round_ctr_reg <= 4'd0;
                  ready_reg     <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.round     = round_ctr_reg;
   assign bus.new_block = block_reg;
   assign bus.ready     = ready_reg;

endmodule
